// File: rtl/my_16regbank.sv
// Sixteen-entry W-bit register bank with one-hot write decode, write acknowledge and write counter.
// Define MY_16REGBANK_R0ZERO_EN to make r0 a constant-zero register (writes to address 0 still acknowledged).
module my_16regbank #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         wr_en,
   input  logic [3:0]   wr_addr,
   input  logic [W-1:0] wr_data,
   output logic [W-1:0] r0,
   output logic [W-1:0] r1,
   output logic [W-1:0] r2,
   output logic [W-1:0] r3,
   output logic [W-1:0] r4,
   output logic [W-1:0] r5,
   output logic [W-1:0] r6,
   output logic [W-1:0] r7,
   output logic [W-1:0] r8,
   output logic [W-1:0] r9,
   output logic [W-1:0] r10,
   output logic [W-1:0] r11,
   output logic [W-1:0] r12,
   output logic [W-1:0] r13,
   output logic [W-1:0] r14,
   output logic [W-1:0] r15,
   output logic [15:0]  last_onehot,
   output logic         wr_done,
   output logic [7:0]   wr_count
);

`ifdef MY_16REGBANK_R0ZERO_EN
   localparam bit R0_ZERO = 1'b1;
`else
   localparam bit R0_ZERO = 1'b0;
`endif

   logic [15:0]        wr_sel;
   logic               wr_accept;
   logic [15:0][W-1:0] bank;

   // NOTE: every variable written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      wr_sel          = '0;
      wr_sel[wr_addr] = 1'b1;
   end

   // clr outranks a coincident write; rst is handled by priority inside the flops.
   assign wr_accept = wr_en & ~clr;

   // NOTE: sequential state uses non-blocking assignments so all flops sample the same pre-edge values.
   // NOTE: the bank is reset because its cleared contents are architecturally visible on r0..r15.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         bank <= '0;
      end else if (wr_en) begin
         for (int i = 0; i < 16; i++) begin
            if (wr_sel[i] && !(R0_ZERO && i == 0)) begin
               bank[i] <= wr_data;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_onehot <= '0;
         wr_done     <= 1'b0;
         wr_count    <= '0;
      end else begin
         wr_done <= wr_accept;
         if (wr_accept) begin
            last_onehot <= wr_sel;
            wr_count    <= wr_count + 8'd1;
         end
      end
   end

`ifdef MY_16REGBANK_R0ZERO_EN
   assign r0  = '0;
`else
   assign r0  = bank[0];
`endif
   assign r1  = bank[1];
   assign r2  = bank[2];
   assign r3  = bank[3];
   assign r4  = bank[4];
   assign r5  = bank[5];
   assign r6  = bank[6];
   assign r7  = bank[7];
   assign r8  = bank[8];
   assign r9  = bank[9];
   assign r10 = bank[10];
   assign r11 = bank[11];
   assign r12 = bank[12];
   assign r13 = bank[13];
   assign r14 = bank[14];
   assign r15 = bank[15];

   // With r0 hard-wired to zero its flop only feeds nothing; keep it referenced so lint stays quiet.
   logic unused_bank0;
   assign unused_bank0 = ^bank[0];

endmodule

// File: tb/tb_my_16regbank.sv
// Self-checking bench for my_16regbank: directed vector table, counter wrap sweep and random traffic vs a reference model.
module tb_my_16regbank;
   localparam int W = 4;
`ifdef MY_16REGBANK_R0ZERO_EN
   localparam bit R0Z = 1'b1;
`else
   localparam bit R0Z = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst, clr, wr_en;
   logic [3:0]   wr_addr;
   logic [W-1:0] wr_data;
   logic [W-1:0] r0, r1, r2, r3, r4, r5, r6, r7, r8, r9, r10, r11, r12, r13, r14, r15;
   logic [15:0]  last_onehot;
   logic         wr_done;
   logic [7:0]   wr_count;
   logic [W-1:0] rq [16];

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state.
   logic [W-1:0] m_reg [16];
   logic [15:0]  m_oh;
   logic         m_done;
   int           m_cnt;

   always #5 clk = ~clk;

   my_16regbank #(.W(W)) dut (
      .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .r0(r0), .r1(r1), .r2(r2), .r3(r3), .r4(r4), .r5(r5), .r6(r6), .r7(r7),
      .r8(r8), .r9(r9), .r10(r10), .r11(r11), .r12(r12), .r13(r13), .r14(r14), .r15(r15),
      .last_onehot(last_onehot), .wr_done(wr_done), .wr_count(wr_count)
   );

   assign rq[0]  = r0;  assign rq[1]  = r1;  assign rq[2]  = r2;  assign rq[3]  = r3;
   assign rq[4]  = r4;  assign rq[5]  = r5;  assign rq[6]  = r6;  assign rq[7]  = r7;
   assign rq[8]  = r8;  assign rq[9]  = r9;  assign rq[10] = r10; assign rq[11] = r11;
   assign rq[12] = r12; assign rq[13] = r13; assign rq[14] = r14; assign rq[15] = r15;

   typedef struct {
      logic         rst;
      logic         clr;
      logic         en;
      logic [3:0]   addr;
      logic [W-1:0] data;
      int           chk_addr;
      logic [W-1:0] exp_val;
      logic [15:0]  exp_oh;
      logic         exp_done;
      logic [7:0]   exp_cnt;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mkv(logic rs, logic cl, logic en, logic [3:0] a, logic [W-1:0] d,
                                int ca, logic [W-1:0] ev, logic [15:0] eo, logic ed, logic [7:0] ec);
      vec_t v;
      v.rst = rs; v.clr = cl; v.en = en; v.addr = a; v.data = d;
      v.chk_addr = ca; v.exp_val = ev; v.exp_oh = eo; v.exp_done = ed; v.exp_cnt = ec;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Spec-level behaviour of one clock edge.
   task automatic model_edge(input logic rs, input logic cl, input logic en,
                             input logic [3:0] a, input logic [W-1:0] d);
      if (rs) begin
         foreach (m_reg[i]) m_reg[i] = '0;
         m_oh = '0; m_done = 1'b0; m_cnt = 0;
      end else begin
         if (cl) begin
            foreach (m_reg[i]) m_reg[i] = '0;
         end else if (en && !(R0Z && a == 4'd0)) begin
            m_reg[a] = d;
         end
         m_done = en && !cl;
         if (en && !cl) begin
            m_oh  = 16'h0001 << a;
            m_cnt = (m_cnt + 1) % 256;
         end
      end
   endtask

   task automatic compare_model(input string tag);
      for (int i = 0; i < 16; i++) check($sformatf("%s r%0d", tag, i), 32'(rq[i]), 32'(m_reg[i]));
      check({tag, " last_onehot"}, 32'(last_onehot), 32'(m_oh));
      check({tag, " wr_done"}, 32'(wr_done), 32'(m_done));
      check({tag, " wr_count"}, 32'(wr_count), 32'(m_cnt));
   endtask

   // Drive one cycle of inputs, clock it, and compare the full state one step after the edge.
   task automatic step(input logic rs, input logic cl, input logic en,
                       input logic [3:0] a, input logic [W-1:0] d, input string tag);
      rst = rs; clr = cl; wr_en = en; wr_addr = a; wr_data = d;
      @(posedge clk);
      model_edge(rs, cl, en, a, d);
      #1;
      compare_model(tag);
   endtask

   initial begin
      rst = 1'b1; clr = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;

      vecs.push_back(mkv(1, 0, 0, 0,  0,   0,  0,   16'h0000, 0, 0));
      vecs.push_back(mkv(0, 0, 0, 0,  0,   0,  0,   16'h0000, 0, 0));
      vecs.push_back(mkv(0, 0, 0, 0,  0,   7,  0,   16'h0000, 0, 0));
      vecs.push_back(mkv(0, 0, 0, 0,  0,   15, 0,   16'h0000, 0, 0));
      vecs.push_back(mkv(0, 0, 1, 5,  4'hA, 5, 4'hA, 16'h0020, 1, 1));
      vecs.push_back(mkv(0, 0, 1, 15, 4'h3, 15, 4'h3, 16'h8000, 1, 2));
      vecs.push_back(mkv(0, 0, 0, 0,  0,   5,  4'hA, 16'h8000, 0, 2));
      vecs.push_back(mkv(0, 1, 1, 2,  4'h7, 2, 0,   16'h8000, 0, 2));
      vecs.push_back(mkv(0, 0, 0, 0,  0,   5,  0,   16'h8000, 0, 2));
      vecs.push_back(mkv(0, 0, 1, 0,  4'hF, 0, R0Z ? 4'h0 : 4'hF, 16'h0001, 1, 3));
      vecs.push_back(mkv(0, 0, 1, 0,  4'h2, 0, R0Z ? 4'h0 : 4'h2, 16'h0001, 1, 4));
      vecs.push_back(mkv(1, 0, 1, 9,  4'h5, 9, 0,   16'h0000, 0, 0));
      vecs.push_back(mkv(0, 0, 1, 9,  4'h6, 9, 4'h6, 16'h0200, 1, 1));
      vecs.push_back(mkv(1, 0, 0, 0,  0,   9,  0,   16'h0000, 0, 0));
      vecs.push_back(mkv(0, 0, 0, 0,  0,   9,  0,   16'h0000, 0, 0));
      vecs.push_back(mkv(1, 1, 1, 3,  4'h9, 3, 0,   16'h0000, 0, 0));

      foreach (vecs[k]) begin
         string tag;
         tag = $sformatf("vec%0d", k);
         step(vecs[k].rst, vecs[k].clr, vecs[k].en, vecs[k].addr, vecs[k].data, tag);
         check({tag, " reg"}, 32'(rq[vecs[k].chk_addr]), 32'(vecs[k].exp_val));
         check({tag, " onehot"}, 32'(last_onehot), 32'(vecs[k].exp_oh));
         check({tag, " done"}, 32'(wr_done), 32'(vecs[k].exp_done));
         check({tag, " count"}, 32'(wr_count), 32'(vecs[k].exp_cnt));
      end

      // 256 writes: counter wraps to 0 and every register ends holding its own index.
      step(1, 0, 0, 0, 0, "wrap_rst");
      for (int i = 0; i < 256; i++) step(0, 0, 1, 4'(i % 16), W'(i % 16), "wrap");
      step(0, 0, 0, 0, 0, "wrap_idle");
      check("wrap count", 32'(wr_count), 32'd0);
      for (int n = 0; n < 16; n++) check($sformatf("wrap r%0d", n), 32'(rq[n]), 32'(n));

      // Back-to-back writes keep wr_done high without a gap.
      step(0, 0, 1, 4'd3, 4'h1, "b2b0");
      step(0, 0, 1, 4'd4, 4'h2, "b2b1");
      check("b2b done", 32'(wr_done), 32'd1);
      step(0, 0, 0, 0, 0, "b2b_end");
      check("b2b done drop", 32'(wr_done), 32'd0);

      // Random traffic against the model.
      for (int i = 0; i < 400; i++) begin
         logic rs, cl, en;
         rs = ($urandom_range(31) == 0);
         cl = ($urandom_range(7) == 0);
         en = $urandom_range(1) == 1;
         step(rs, cl, en, 4'($urandom_range(15)), W'($urandom), "rand");
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
